reg_file_sb: RTL and testbench

//  Parametrised multi-read-port register file with a pending-write scoreboard for the pipelined ONC-16 core.

---
 rtl/reg_file_sb_pkg.sv | 27 ++
 rtl/reg_file_sb_if.sv | 35 +++
 rtl/reg_file_sb_rf_scoreboard.sv | 69 ++++++
 rtl/reg_file_sb.sv | 76 +++++++
 tb/tb_reg_file_sb.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_sb_pkg
// Brief   : Shared defaults and pending-bit helper for the register file.
// Revision: 1.0 - initial release
// ============================================================================
package reg_file_sb_pkg;

   localparam int RF_DATA_W = 16;
   localparam int RF_ADDR_W = 4;
   localparam int RF_NUM_RD = 2;

   typedef enum logic [1:0] {
      PEND_HOLD  = 2'd0,
      PEND_SET   = 2'd1,
      PEND_CLEAR = 2'd2
   } pend_op_e;

   // A new producer supersedes the one being written back, so issue wins.
   function automatic pend_op_e pend_op(input logic iss_hit, input logic wb_hit);
      if (iss_hit) return PEND_SET;
      if (wb_hit)  return PEND_CLEAR;
      return PEND_HOLD;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_sb_if.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_sb_if
// Brief   : Read, writeback and issue bus of the register file.
// Revision: 1.0 - initial release
// ============================================================================
interface reg_file_sb_if
   import reg_file_sb_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NUM_RD = RF_NUM_RD
);
   logic [NUM_RD*ADDR_W-1:0] r_addr;
   logic [NUM_RD*DATA_W-1:0] r_data;
   logic [NUM_RD-1:0]        r_busy;
   logic                     we;
   logic [ADDR_W-1:0]        w_addr;
   logic [DATA_W-1:0]        w_data;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_addr;
   logic                     flush;
   logic                     stall;

   modport master (
      output r_addr, we, w_addr, w_data, iss_en, iss_addr, flush,
      input  r_data, r_busy, stall
   );

   modport slave (
      input  r_addr, we, w_addr, w_data, iss_en, iss_addr, flush,
      output r_data, r_busy, stall
   );
endinterface
`default_nettype wire

// File: rtl/reg_file_sb_rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : rf_scoreboard
// Brief   : Pending-write bit per register with per-read-port busy lookup.
// Revision: 1.0 - initial release
// ============================================================================
module rf_scoreboard
   import reg_file_sb_pkg::*;
#(
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_RD   = RF_NUM_RD,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input  logic                     clock,
   input  logic                     rst,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        w_addr,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   input  logic                     flush,
   input  logic [NUM_RD*ADDR_W-1:0] r_addr,
   output logic [NUM_RD-1:0]        r_busy,
   output logic                     stall
);
   localparam int c_depth = 2**ADDR_W;

   logic [c_depth-1:0] r_pending;
   pend_op_e           w_op [c_depth];

   generate
      for (genvar i = 0; i < c_depth; i++) begin : g_pend_op
         logic w_iss_hit;
         logic w_wb_hit;
         assign w_iss_hit = iss_en && (iss_addr == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0));
         assign w_wb_hit  = we && (w_addr == ADDR_W'(i));
         assign w_op[i]   = pend_op(w_iss_hit, w_wb_hit);
      end
   endgenerate

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_pending <= '0;
      end else if (flush) begin
         r_pending <= '0;
      end else begin
         for (int i = 0; i < c_depth; i++) begin
            case (w_op[i])
               PEND_SET:   r_pending[i] <= 1'b1;
               PEND_CLEAR: r_pending[i] <= 1'b0;
               default:    r_pending[i] <= r_pending[i];
            endcase
         end
      end
   end

   // A same-cycle writeback is forwarded by the bypass, so it no longer blocks.
   always_comb begin
      r_busy = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         r_busy[p] = r_pending[r_addr[p*ADDR_W +: ADDR_W]]
                     && !((BYPASS != 0) && we && (w_addr == r_addr[p*ADDR_W +: ADDR_W]));
      end
   end

   assign stall = |r_busy;

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_sb
// Brief   : Multi-read-port register file with bypass and pending scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module reg_file_sb
   import reg_file_sb_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_RD   = RF_NUM_RD,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input logic          clock,
   input logic          rst,
   reg_file_sb_if.slave bus
);
   localparam int c_depth = 2**ADDR_W;

   logic [DATA_W-1:0] r_mem [c_depth];
   logic [DATA_W-1:0] w_rd  [NUM_RD];
   logic              w_wr_en;

   assign w_wr_en = bus.we && !((ZERO_REG != 0) && (bus.w_addr == '0));

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < c_depth; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_mem[bus.w_addr] <= bus.w_data;
      end
   end

   generate
      for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
         logic [ADDR_W-1:0] w_ra;
         logic              w_is_zero;
         logic              w_fwd;
         assign w_ra      = bus.r_addr[p*ADDR_W +: ADDR_W];
         assign w_is_zero = (ZERO_REG != 0) && (w_ra == '0);
         assign w_fwd     = (BYPASS != 0) && bus.we && (bus.w_addr == w_ra);
         assign w_rd[p]   = w_is_zero ? '0 : (w_fwd ? bus.w_data : r_mem[w_ra]);
      end
   endgenerate

   always_comb begin
      bus.r_data = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         bus.r_data[p*DATA_W +: DATA_W] = w_rd[p];
      end
   end

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NUM_RD   (NUM_RD),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clock    (clock),
      .rst      (rst),
      .we       (bus.we),
      .w_addr   (bus.w_addr),
      .iss_en   (bus.iss_en),
      .iss_addr (bus.iss_addr),
      .flush    (bus.flush),
      .r_addr   (bus.r_addr),
      .r_busy   (bus.r_busy),
      .stall    (bus.stall)
   );

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_reg_file_sb
// Brief   : Bench for reg_file_sb; unit A has bypass, unit B has zero reg only.
// Revision: 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

   logic clock = 1'b0;
   logic rst;

   always #5 clock = ~clock;

   reg_file_sb_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) bus_a ();
   reg_file_sb_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) bus_b ();

   reg_file_sb #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .BYPASS(1), .ZERO_REG(0)) dut_a (
      .clock (clock),
      .rst   (rst),
      .bus   (bus_a.slave)
   );

   reg_file_sb #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
      .clock (clock),
      .rst   (rst),
      .bus   (bus_b.slave)
   );

   typedef struct {
      logic        we;
      logic [3:0]  wa;
      logic [15:0] wd;
      logic        iss;
      logic [3:0]  ia;
      logic        fl;
      logic [3:0]  ra0;
      logic [3:0]  ra1;
      logic [15:0] a_d0;
      logic [15:0] a_d1;
      logic [1:0]  a_bz;
      logic [15:0] b_d0;
      logic [15:0] b_d1;
      logic [1:0]  b_bz;
   } vec_t;

   typedef struct {
      logic [15:0] d0;
      logic [15:0] d1;
      logic [1:0]  bz;
   } exp_t;

   localparam int c_nvec = 11;

   vec_t tbl [c_nvec];
   exp_t sb_a [$];
   exp_t sb_b [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_dut(input int which, input string tag, input exp_t e);
      logic [15:0] d0, d1;
      logic [1:0]  bz;
      logic        st;
      if (which == 0) begin
         d0 = bus_a.r_data[15:0];  d1 = bus_a.r_data[31:16];
         bz = bus_a.r_busy;        st = bus_a.stall;
      end else begin
         d0 = bus_b.r_data[15:0];  d1 = bus_b.r_data[31:16];
         bz = bus_b.r_busy;        st = bus_b.stall;
      end
      chk({tag, (which == 0) ? "_a_d0" : "_b_d0"}, d0, e.d0);
      chk({tag, (which == 0) ? "_a_d1" : "_b_d1"}, d1, e.d1);
      chk({tag, (which == 0) ? "_a_busy" : "_b_busy"}, {14'b0, bz}, {14'b0, e.bz});
      chk({tag, (which == 0) ? "_a_stall" : "_b_stall"}, {15'b0, st}, {15'b0, |e.bz});
   endtask

   task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                        input logic iss, input logic [3:0] ia, input logic fl,
                        input logic [3:0] ra0, input logic [3:0] ra1);
      bus_a.we = we;  bus_a.w_addr = wa;  bus_a.w_data = wd;
      bus_a.iss_en = iss;  bus_a.iss_addr = ia;  bus_a.flush = fl;
      bus_a.r_addr = {ra1, ra0};
      bus_b.we = we;  bus_b.w_addr = wa;  bus_b.w_data = wd;
      bus_b.iss_en = iss;  bus_b.iss_addr = ia;  bus_b.flush = fl;
      bus_b.r_addr = {ra1, ra0};
   endtask

   task automatic rd(input logic [3:0] ra0, input logic [3:0] ra1);
      drive(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 1'b0, ra0, ra1);
   endtask

   task automatic both(input string tag, input exp_t ea, input exp_t eb);
      chk_dut(0, tag, ea);
      chk_dut(1, tag, eb);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded 200000 ns, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t ea, eb;
      // inputs: we wa wd iss ia fl ra0 ra1 | A: d0 d1 bz | B: d0 d1 bz
      tbl[0]  = '{1'b1, 4'h8, 16'h8000, 1'b0, 4'h0, 1'b0, 4'h8, 4'h7, 16'h8000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 2'b00};
      tbl[1]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 1'b0, 4'h8, 4'h8, 16'h8000, 16'h8000, 2'b00, 16'h8000, 16'h8000, 2'b00};
      tbl[2]  = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h5, 1'b0, 4'h5, 4'h0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 2'b00};
      tbl[3]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 1'b0, 4'h0, 4'h5, 16'h0000, 16'h0000, 2'b10, 16'h0000, 16'h0000, 2'b10};
      tbl[4]  = '{1'b1, 4'h5, 16'h0055, 1'b0, 4'h0, 1'b0, 4'h5, 4'h5, 16'h0055, 16'h0055, 2'b00, 16'h0000, 16'h0000, 2'b11};
      tbl[5]  = '{1'b1, 4'h0, 16'hFFFF, 1'b1, 4'h0, 1'b0, 4'h0, 4'h5, 16'hFFFF, 16'h0055, 2'b00, 16'h0000, 16'h0055, 2'b00};
      tbl[6]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 1'b0, 4'h0, 4'h8, 16'hFFFF, 16'h8000, 2'b01, 16'h0000, 16'h8000, 2'b00};
      tbl[7]  = '{1'b1, 4'h2, 16'h1234, 1'b1, 4'h2, 1'b0, 4'h2, 4'h0, 16'h1234, 16'hFFFF, 2'b10, 16'h0000, 16'h0000, 2'b00};
      tbl[8]  = '{1'b1, 4'h9, 16'hBEEF, 1'b1, 4'hC, 1'b1, 4'h2, 4'hC, 16'h1234, 16'h0000, 2'b01, 16'h1234, 16'h0000, 2'b01};
      tbl[9]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 1'b0, 4'h9, 4'h2, 16'hBEEF, 16'h1234, 2'b00, 16'hBEEF, 16'h1234, 2'b00};
      tbl[10] = '{1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 1'b0, 4'h0, 4'hC, 16'hFFFF, 16'h0000, 2'b00, 16'h0000, 16'h0000, 2'b00};

      rst = 1'b1;
      rd(4'h0, 4'hF);
      @(negedge clock);
      #1;
      both("reset_state", '{16'h0000, 16'h0000, 2'b00}, '{16'h0000, 16'h0000, 2'b00});
      @(negedge clock);
      rst = 1'b0;

      for (int i = 0; i < c_nvec; i++) begin
         drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].iss, tbl[i].ia, tbl[i].fl, tbl[i].ra0, tbl[i].ra1);
         sb_a.push_back('{tbl[i].a_d0, tbl[i].a_d1, tbl[i].a_bz});
         sb_b.push_back('{tbl[i].b_d0, tbl[i].b_d1, tbl[i].b_bz});
         #1;
         if (sb_a.size() == 0 || sb_b.size() == 0) begin
            chk($sformatf("vec%0d_queue", i), 16'h0000, 16'h0001);
         end else begin
            ea = sb_a.pop_front();
            eb = sb_b.pop_front();
            both($sformatf("vec%0d", i), ea, eb);
         end
         @(negedge clock);
      end

      // Asynchronous reset mid-cycle, then held over an edge with we/iss active.
      drive(1'b0, 4'h0, 16'h0000, 1'b1, 4'h4, 1'b0, 4'h8, 4'h4);
      @(negedge clock);
      rd(4'h8, 4'h4);
      #1;
      both("pre_rst", '{16'h8000, 16'h0000, 2'b10}, '{16'h8000, 16'h0000, 2'b10});
      #1;
      rst = 1'b1;
      #1;
      both("rst_async", '{16'h0000, 16'h0000, 2'b00}, '{16'h0000, 16'h0000, 2'b00});
      drive(1'b1, 4'h3, 16'h7777, 1'b1, 4'h3, 1'b0, 4'h3, 4'h3);
      for (int a = 0; a < 16; a++) begin
         @(negedge clock);
         rd(4'(a), 4'(a));
         #1;
         both($sformatf("rst_addr%0d", a), '{16'h0000, 16'h0000, 2'b00}, '{16'h0000, 16'h0000, 2'b00});
      end
      @(negedge clock);
      rst = 1'b0;
      rd(4'h3, 4'h4);
      #1;
      both("rst_override", '{16'h0000, 16'h0000, 2'b00}, '{16'h0000, 16'h0000, 2'b00});

      // Bypass versus no-bypass on a same-cycle write.
      @(negedge clock);
      drive(1'b1, 4'h3, 16'hA5A5, 1'b0, 4'h0, 1'b0, 4'h3, 4'h0);
      #1;
      both("bypass_pre", '{16'hA5A5, 16'h0000, 2'b00}, '{16'h0000, 16'h0000, 2'b00});
      @(negedge clock);
      rd(4'h3, 4'h0);
      #1;
      both("bypass_post", '{16'hA5A5, 16'h0000, 2'b00}, '{16'hA5A5, 16'h0000, 2'b00});

      // Issue, then writeback clearing busy.
      @(negedge clock);
      drive(1'b0, 4'h0, 16'h0000, 1'b1, 4'h5, 1'b0, 4'h0, 4'h5);
      @(negedge clock);
      rd(4'h0, 4'h5);
      #1;
      both("sb_busy", '{16'h0000, 16'h0000, 2'b10}, '{16'h0000, 16'h0000, 2'b10});
      drive(1'b1, 4'h5, 16'h0055, 1'b0, 4'h0, 1'b0, 4'h0, 4'h5);
      #1;
      both("sb_wb_same", '{16'h0000, 16'h0055, 2'b00}, '{16'h0000, 16'h0000, 2'b10});
      @(negedge clock);
      rd(4'h0, 4'h5);
      #1;
      both("sb_wb_post", '{16'h0000, 16'h0055, 2'b00}, '{16'h0000, 16'h0055, 2'b00});

      // Issue and writeback to a pending register on the same edge.
      @(negedge clock);
      drive(1'b0, 4'h0, 16'h0000, 1'b1, 4'h2, 1'b0, 4'h0, 4'h0);
      @(negedge clock);
      drive(1'b1, 4'h2, 16'h1234, 1'b1, 4'h2, 1'b0, 4'h0, 4'h0);
      @(negedge clock);
      rd(4'h2, 4'h2);
      #1;
      both("collision", '{16'h1234, 16'h1234, 2'b11}, '{16'h1234, 16'h1234, 2'b11});

      // Flush beats a simultaneous issue.
      @(negedge clock);
      drive(1'b0, 4'h0, 16'h0000, 1'b1, 4'h1, 1'b0, 4'h0, 4'h0);
      @(negedge clock);
      drive(1'b0, 4'h0, 16'h0000, 1'b1, 4'h9, 1'b0, 4'h0, 4'h0);
      @(negedge clock);
      drive(1'b0, 4'h0, 16'h0000, 1'b1, 4'hC, 1'b1, 4'h1, 4'h9);
      #1;
      both("flush_pre", '{16'h0000, 16'h0000, 2'b11}, '{16'h0000, 16'h0000, 2'b11});
      @(negedge clock);
      rd(4'h1, 4'h9);
      #1;
      both("flush_1_9", '{16'h0000, 16'h0000, 2'b00}, '{16'h0000, 16'h0000, 2'b00});
      rd(4'hC, 4'h2);
      #1;
      both("flush_c_2", '{16'h0000, 16'h1234, 2'b00}, '{16'h0000, 16'h1234, 2'b00});

      // Register 0: hard zero on unit B, ordinary register on unit A.
      @(negedge clock);
      drive(1'b1, 4'h0, 16'hFFFF, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0);
      #1;
      both("zero_pre", '{16'hFFFF, 16'hFFFF, 2'b00}, '{16'h0000, 16'h0000, 2'b00});
      @(negedge clock);
      rd(4'h0, 4'h0);
      #1;
      both("zero_post", '{16'hFFFF, 16'hFFFF, 2'b11}, '{16'h0000, 16'h0000, 2'b00});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
